serial_add_ctrl: RTL and testbench

- Bit-serial adder sequencer that sits directly around the team's 1-bit full adder cell.
- Upstream role: latches two WIDTH-bit operands and drives the adder's a/b/cin inputs one bit per cycle, LSB first.
- Downstream role: captures the adder's sum/carry outputs each cycle and assembles the WIDTH-bit result plus carry-out.
- The full adder is external and purely combinational: fa_sum/fa_carry are valid in the same cycle fa_a/fa_b/fa_cin are driven.

---
 rtl/serial_add_ctrl.sv | 135 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer wrapped around an external combinational 1-bit full adder.
// Optional subtract mode (sub input, ovf output) is enabled by defining SERIAL_SUB_EN.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_carry
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    result_d = result_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    load     = 1'b0;

    case (state_q)
      IDLE: begin
        load = start;
      end
      RUN: begin
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        result_d = {fa_sum, result_q[WIDTH-1:1]};
        carry_d  = fa_carry;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          cout_d  = fa_carry;
          // Signed overflow: carry into the MSB stage differs from carry out of it.
          ovf_d   = carry_q ^ fa_carry;
          cnt_d   = '0;
          state_d = IDLE;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        load    = start;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Accepting a start is identical from IDLE and DONE.
    if (load) begin
      sa_d    = op_a;
      cnt_d   = '0;
      state_d = RUN;
`ifdef SERIAL_SUB_EN
      sb_d    = sub ? ~op_b : op_b;
      carry_d = sub;
`else
      sb_d    = op_b;
      carry_d = 1'b0;
`endif
    end
  end

  always_comb begin
    busy   = (state_q == RUN);
    done   = (state_q == DONE);
    fa_a   = (state_q == RUN) ? sa_q[0] : 1'b0;
    fa_b   = (state_q == RUN) ? sb_q[0] : 1'b0;
    fa_cin = (state_q == RUN) ? carry_q : 1'b0;
  end

  assign result = result_q;
  assign cout   = cout_q;
`ifdef SERIAL_SUB_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8) with a behavioural full adder in the loop.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sub;
  logic             ovf;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             fa_a;
  logic             fa_b;
  logic             fa_cin;
  logic             fa_sum;
  logic             fa_carry;

  int vectors;
  int miscompares;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
`ifdef SERIAL_SUB_EN
    .sub      (sub),
    .ovf      (ovf),
`endif
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .fa_a     (fa_a),
    .fa_b     (fa_b),
    .fa_cin   (fa_cin),
    .fa_sum   (fa_sum),
    .fa_carry (fa_carry)
  );

  // External full adder cell
  assign fa_sum   = fa_a ^ fa_b ^ fa_cin;
  assign fa_carry = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
    op_a  = a;
    op_b  = b;
    sub   = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic count_done(input int n, output int c);
    c = 0;
    for (int k = 0; k < n; k++) begin
      if (done === 1'b1) c++;
      tick();
    end
  endtask

  initial begin
    logic [7:0] pat_a;
    logic [7:0] pat_b;
    int         ndone;

    vectors     = 0;
    miscompares = 0;
    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    sub   = 1'b0;
    tick();
    tick();

    chk("rst_busy",   busy,   0);
    chk("rst_done",   done,   0);
    chk("rst_result", result, 0);
    chk("rst_cout",   cout,   0);
    chk("rst_fa",     {fa_a, fa_b, fa_cin}, 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // 0x5A + 0x3C with an ignored start pulse during the run
    pat_a = 8'h5A;
    pat_b = 8'h3C;
    issue(8'h5A, 8'h3C, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("run1_busy", busy, 1);
      chk("run1_done", done, 0);
      chk("run1_fa_a", fa_a, pat_a[i]);
      chk("run1_fa_b", fa_b, pat_b[i]);
      start = (i == 2);
      if (i == 2) begin
        op_a = 8'h01;
        op_b = 8'h01;
      end
      tick();
    end
    start = 1'b0;
    chk("add1_done",   done,   1);
    chk("add1_busy",   busy,   0);
    chk("add1_result", result, 8'h96);
    chk("add1_cout",   cout,   0);
    tick();
    chk("add1_done_pulse", done,   0);
    chk("add1_hold",       result, 8'h96);
    count_done(12, ndone);
    chk("add1_no_second_done", ndone, 0);
    chk("add1_hold_late",      result, 8'h96);

    // 0xFF + 0x01: carry ripples through every stage
    issue(8'hFF, 8'h01, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("run2_fa_cin", fa_cin, (i == 0) ? 0 : 1);
      tick();
    end
    chk("add2_done",   done,   1);
    chk("add2_result", result, 8'h00);
    chk("add2_cout",   cout,   1);
    tick();

    // Reset in the middle of a run
    issue(8'h5A, 8'h3C, 1'b0);
    tick();
    tick();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy",   busy,   0);
    chk("mid_rst_done",   done,   0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_cout",   cout,   0);
    chk("mid_rst_fa",     {fa_a, fa_b, fa_cin}, 0);
    count_done(12, ndone);
    chk("mid_rst_no_done", ndone, 0);
    issue(8'h10, 8'h20, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    chk("add3_done",   done,   1);
    chk("add3_result", result, 8'h30);
    chk("add3_cout",   cout,   0);
    tick();

    // Back-to-back: start accepted in the DONE cycle
    issue(8'h80, 8'h80, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    chk("add4_done",   done,   1);
    chk("add4_result", result, 8'h00);
    chk("add4_cout",   cout,   1);
    issue(8'h80, 8'h80, 1'b0);
    chk("b2b_busy", busy, 1);
    chk("b2b_done", done, 0);
    for (int i = 0; i < 8; i++) begin
      chk("b2b_run_busy", busy, 1);
      tick();
    end
    chk("add5_done",   done,   1);
    chk("add5_result", result, 8'h00);
    chk("add5_cout",   cout,   1);
    tick();
    chk("add5_idle", done, 0);

`ifdef SERIAL_SUB_EN
    issue(8'h10, 8'h01, 1'b1);
    for (int i = 0; i < 8; i++) tick();
    chk("sub1_done",   done,   1);
    chk("sub1_result", result, 8'h0F);
    chk("sub1_cout",   cout,   1);
    chk("sub1_ovf",    ovf,    0);
    tick();
    issue(8'h80, 8'h01, 1'b1);
    for (int i = 0; i < 8; i++) tick();
    chk("sub2_done",   done,   1);
    chk("sub2_result", result, 8'h7F);
    chk("sub2_ovf",    ovf,    1);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
